// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the external-memory access controller:
// size codes, one-hot FSM states, request owner and small helpers.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_WAIT    = 3'b010,
        ST_RELEASE = 3'b100
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Byte count handed to the engine; the reserved code 11 behaves as a word.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SIZE_BYTE: n = 3'd1;
            SIZE_HALF: n = 3'd2;
            default:   n = 3'd4;
        endcase
        return n;
    endfunction

    // Half on an odd address, or word not on a 4-byte boundary.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic m;
        case (size)
            SIZE_BYTE: m = 1'b0;
            SIZE_HALF: m = addr_lo[0];
            default:   m = (addr_lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Converts the engine's MSB-first receive word into little-endian data.
// Received bytes are right-aligned with the first (lowest-address) byte
// most significant; stale upper bits are masked and the result extended.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [15:0] w_half;

    assign w_half = {i_rdata[7:0], i_rdata[15:8]};

    // Select the byte order and extension for the requested access size.
    always_comb begin
        o_data = 32'h0000_0000;
        case (i_size)
            SIZE_BYTE: o_data = {{24{~i_unsigned & i_rdata[7]}}, i_rdata[7:0]};
            SIZE_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
            default:   o_data = {i_rdata[7:0], i_rdata[15:8], i_rdata[23:16], i_rdata[31:24]};
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates instruction fetch and load/store requests onto the SPI
// external-memory engine, sequences start_request including its release
// cycle, and returns little-endian extended read data.
// Optional: MEM_CTRL_MISALIGN_CHECK_EN rejects misaligned loads/stores
// without an engine transaction and adds the ls_misalign output.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic              ls_write,
    input  logic [1:0]        ls_size,
    input  logic              ls_unsigned,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata,
    output logic              busy,
    output logic              mem_start,
    output logic [2:0]        mem_num_bytes,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_is_write,
    output logic [31:0]       mem_wdata,
    input  logic              mem_done,
    input  logic [31:0]       mem_rdata
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    ,
    output logic              ls_misalign
`endif
);

    state_e      r_state;
    owner_e      r_owner;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] w_aligned;
    logic        w_ls_misalign;

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    assign w_ls_misalign = is_misaligned(ls_size, ls_addr[1:0]);
`else
    assign w_ls_misalign = 1'b0;
`endif

    load_align u_load_align (
        .i_rdata    (mem_rdata),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_data     (w_aligned)
    );

    // Request FSM: issue, wait for the engine, then one forced release cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_owner       <= OWN_IF;
            r_size        <= SIZE_BYTE;
            r_unsigned    <= 1'b0;
            mem_start     <= 1'b0;
            mem_num_bytes <= 3'd0;
            mem_addr      <= '0;
            mem_is_write  <= 1'b0;
            mem_wdata     <= 32'h0000_0000;
            if_done       <= 1'b0;
            ls_done       <= 1'b0;
            if_rdata      <= 32'h0000_0000;
            ls_rdata      <= 32'h0000_0000;
            busy          <= 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
            ls_misalign   <= 1'b0;
`endif
        end else begin
            if_done <= 1'b0;
            ls_done <= 1'b0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
            ls_misalign <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (ls_req && w_ls_misalign) begin
                        // Rejected without touching the engine.
                        mem_start <= 1'b0;
                        ls_done   <= 1'b1;
                        ls_rdata  <= 32'h0000_0000;
                        busy      <= 1'b1;
                        r_state   <= ST_RELEASE;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
                        ls_misalign <= 1'b1;
`endif
                    end else if (ls_req) begin
                        r_owner       <= OWN_LS;
                        r_size        <= ls_size;
                        r_unsigned    <= ls_unsigned;
                        mem_num_bytes <= size_to_bytes(ls_size);
                        mem_addr      <= ls_addr;
                        mem_is_write  <= ls_write;
                        mem_wdata     <= ls_wdata;
                        mem_start     <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= ST_WAIT;
                    end else if (if_req) begin
                        r_owner       <= OWN_IF;
                        r_size        <= SIZE_WORD;
                        r_unsigned    <= 1'b1;
                        mem_num_bytes <= 3'd4;
                        mem_addr      <= if_addr;
                        mem_is_write  <= 1'b0;
                        mem_wdata     <= 32'h0000_0000;
                        mem_start     <= 1'b1;
                        busy          <= 1'b1;
                        r_state       <= ST_WAIT;
                    end else begin
                        mem_start <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        mem_start <= 1'b0;
                        r_state   <= ST_RELEASE;
                        if (r_owner == OWN_IF) begin
                            if_done  <= 1'b1;
                            if_rdata <= w_aligned;
                        end else begin
                            ls_done  <= 1'b1;
                            ls_rdata <= mem_is_write ? 32'h0000_0000 : w_aligned;
                        end
                    end else begin
                        mem_start <= 1'b1;
                        r_state   <= ST_WAIT;
                    end
                end
                ST_RELEASE: begin
                    // Engine needs start low for a cycle to return to idle.
                    mem_start <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    mem_start <= 1'b0;
                    busy      <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed transactions against a
// simple engine model, with a transaction-level scoreboard compared on
// every falling edge plus hand-computed literal results.
module tb_mem_access_ctrl;

    typedef struct {
        bit          own_ls;
        logic [16:0] addr;
        bit          wr;
        int          nb;
        logic [31:0] wdata;
        logic [31:0] r;
        logic [31:0] rdata;
        bit          mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [16:0] if_addr = 17'h0;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic [16:0] ls_addr = 17'h0;
    logic        ls_write = 1'b0;
    logic [1:0]  ls_size = 2'b00;
    logic        ls_unsigned = 1'b0;
    logic [31:0] ls_wdata = 32'h0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        busy;
    logic        mem_start;
    logic [2:0]  mem_num_bytes;
    logic [16:0] mem_addr;
    logic        mem_is_write;
    logic [31:0] mem_wdata;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
    logic        ls_misalign;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   eng_lat = 3;
    exp_t q[$];
    logic [31:0] last_if = 32'h0;
    logic [31:0] last_ls = 32'h0;

    mem_access_ctrl #(.ADDR_W(17)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_done       (if_done),
        .if_rdata      (if_rdata),
        .ls_req        (ls_req),
        .ls_addr       (ls_addr),
        .ls_write      (ls_write),
        .ls_size       (ls_size),
        .ls_unsigned   (ls_unsigned),
        .ls_wdata      (ls_wdata),
        .ls_done       (ls_done),
        .ls_rdata      (ls_rdata),
        .busy          (busy),
        .mem_start     (mem_start),
        .mem_num_bytes (mem_num_bytes),
        .mem_addr      (mem_addr),
        .mem_is_write  (mem_is_write),
        .mem_wdata     (mem_wdata),
        .mem_done      (mem_done),
        .mem_rdata     (mem_rdata)
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        ,
        .ls_misalign   (ls_misalign)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Received bytes are right-aligned, first byte most significant; that
    // first byte lands at the lowest address of the little-endian result.
    function automatic logic [31:0] model_load(input logic [31:0] r, input int nb, input bit uns);
        logic [63:0] rr;
        logic [63:0] val;
        rr  = {32'h0, r};
        val = 64'h0;
        for (int i = 0; i < nb; i++)
            val = val | (((rr >> (8 * (nb - 1 - i))) & 64'hFF) << (8 * i));
        if (!uns && val[8 * nb - 1])
            val = val | ~((64'd1 << (8 * nb)) - 64'd1);
        return val[31:0];
    endfunction

    function automatic int model_nb(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Engine model: answers after eng_lat cycles of start high.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !mem_start) begin
                cnt = 0;
                mem_done = 1'b0;
            end else begin
                cnt++;
                if (cnt >= eng_lat && q.size() > 0) begin
                    mem_done  = 1'b1;
                    mem_rdata = q[0].r;
                end else begin
                    mem_done = 1'b0;
                end
            end
        end
    end

    // Scoreboard compare on every falling edge.
    initial begin
        bit   prev_done;
        exp_t e;
        bit   exp_mis;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q.delete();
                last_if = 32'h0;
                last_ls = 32'h0;
                prev_done = 1'b0;
            end else begin
                exp_mis = 1'b0;
                if (prev_done) begin
                    check("release_start_low", mem_start, 1'b0);
                    check("release_then_idle", busy, 1'b0);
                    check("done_one_cycle", if_done | ls_done, 1'b0);
                end
                if (mem_start) begin
                    check("busy_while_start", busy, 1'b1);
                    if (q.size() == 0) begin
                        check("unexpected_start", 1'b1, 1'b0);
                    end else begin
                        check("mem_addr", mem_addr, q[0].addr);
                        check("mem_num_bytes", mem_num_bytes, q[0].nb);
                        check("mem_is_write", mem_is_write, q[0].wr);
                        if (q[0].wr) check("mem_wdata", mem_wdata, q[0].wdata);
                    end
                end
                if (if_done || ls_done) begin
                    check("single_done", if_done & ls_done, 1'b0);
                    check("start_low_at_done", mem_start, 1'b0);
                    check("busy_at_done", busy, 1'b1);
                    if (q.size() == 0) begin
                        check("unexpected_done", 1'b1, 1'b0);
                    end else begin
                        e = q.pop_front();
                        check("done_owner", ls_done, e.own_ls);
                        if (e.own_ls) last_ls = e.rdata;
                        else          last_if = e.rdata;
                        exp_mis = e.mis;
                    end
                end
`ifdef MEM_CTRL_MISALIGN_CHECK_EN
                check("ls_misalign", ls_misalign, exp_mis);
`endif
                check("if_rdata_model", if_rdata, last_if);
                check("ls_rdata_model", ls_rdata, last_ls);
                prev_done = if_done | ls_done;
            end
        end
    end

    task automatic do_if(input logic [16:0] addr, input logic [31:0] r, input logic [31:0] lit);
        exp_t e;
        bit   seen;
        e.own_ls = 1'b0; e.addr = addr; e.wr = 1'b0; e.nb = 4; e.wdata = 32'h0;
        e.r = r; e.rdata = model_load(r, 4, 1'b1); e.mis = 1'b0;
        check("model_pin_if", e.rdata, lit);
        q.push_back(e);
        if_addr = addr;
        if_req  = 1'b1;
        @(negedge clk);
        check("if_start_latency", mem_start, 1'b1);
        if_addr = ~addr;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (if_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("if_done_seen", seen, 1'b1);
        if (seen) check("if_rdata_lit", if_rdata, lit);
        if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_ls(input logic [16:0] addr, input bit wr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata, input logic [31:0] r,
                         input logic [31:0] lit, input bit mis);
        exp_t e;
        bit   seen;
        e.own_ls = 1'b1; e.addr = addr; e.wr = wr; e.nb = model_nb(size); e.wdata = wdata;
        e.r = r; e.rdata = (wr || mis) ? 32'h0 : model_load(r, model_nb(size), uns); e.mis = mis;
        check("model_pin_ls", e.rdata, lit);
        q.push_back(e);
        ls_addr = addr; ls_write = wr; ls_size = size; ls_unsigned = uns; ls_wdata = wdata;
        ls_req = 1'b1;
        @(negedge clk);
        check("ls_start_latency", mem_start, !mis);
        ls_addr = ~addr;
        ls_wdata = ~wdata;
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (ls_done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check("ls_done_seen", seen, 1'b1);
        if (seen) check("ls_rdata_lit", ls_rdata, lit);
        ls_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int  ls_seen;
        int  if_seen;
        bit  ls_first;
        exp_t e;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_start", mem_start, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_if_done", if_done, 1'b0);
        check("rst_ls_done", ls_done, 1'b0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_mem_num_bytes", mem_num_bytes, 3'd0);
        check("rst_mem_addr", mem_addr, 17'h0);
        check("rst_mem_is_write", mem_is_write, 1'b0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        eng_lat = 3;
        do_if(17'h00010, 32'h1305_0093, 32'h9300_0513);
        eng_lat = 1;
        do_ls(17'h10005, 1'b0, 2'b00, 1'b0, 32'h0, 32'hA5A5_A580, 32'hFFFF_FF80, 1'b0);
        do_ls(17'h10005, 1'b0, 2'b00, 1'b1, 32'h0, 32'hA5A5_A580, 32'h0000_0080, 1'b0);
        eng_lat = 5;
        do_ls(17'h10006, 1'b0, 2'b01, 1'b0, 32'h0, 32'h7766_3412, 32'h0000_1234, 1'b0);
        do_ls(17'h10006, 1'b0, 2'b01, 1'b0, 32'h0, 32'h1234_34F2, 32'hFFFF_F234, 1'b0);
        do_ls(17'h00008, 1'b0, 2'b01, 1'b1, 32'h0, 32'h0000_34F2, 32'h0000_F234, 1'b0);
        eng_lat = 2;
        do_ls(17'h10008, 1'b0, 2'b11, 1'b0, 32'h0, 32'h0000_00F0, 32'hF000_0000, 1'b0);
        do_ls(17'h10010, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 32'h4433_2211, 1'b0);
        do_ls(17'h10000, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0, 1'b0);
        do_ls(17'h10004, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_007E, 32'h0000_007E, 1'b0);
        do_ls(17'h10003, 1'b1, 2'b00, 1'b0, 32'h0000_00AB, 32'h0, 32'h0, 1'b0);

        // Contention: both requests raised together; load/store first.
        e.own_ls = 1'b1; e.addr = 17'h10001; e.wr = 1'b0; e.nb = 1; e.wdata = 32'h0;
        e.r = 32'h0000_005A; e.rdata = model_load(e.r, 1, 1'b1); e.mis = 1'b0;
        check("model_pin_cont_ls", e.rdata, 32'h0000_005A);
        q.push_back(e);
        e.own_ls = 1'b0; e.addr = 17'h00020; e.nb = 4; e.r = 32'h0102_0304;
        e.rdata = model_load(e.r, 4, 1'b1);
        check("model_pin_cont_if", e.rdata, 32'h0403_0201);
        q.push_back(e);
        ls_addr = 17'h10001; ls_write = 1'b0; ls_size = 2'b00; ls_unsigned = 1'b1;
        if_addr = 17'h00020;
        ls_req = 1'b1;
        if_req = 1'b1;
        ls_seen = 0; if_seen = 0; ls_first = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ls_done) begin
                ls_seen++;
                if (if_seen == 0) ls_first = 1'b1;
                check("cont_ls_rdata", ls_rdata, 32'h0000_005A);
                ls_req = 1'b0;
            end
            if (if_done) begin
                if_seen++;
                check("cont_if_rdata", if_rdata, 32'h0403_0201);
                if_req = 1'b0;
            end
            if (ls_seen > 0 && if_seen > 0) break;
        end
        check("cont_ls_once", ls_seen, 1);
        check("cont_if_once", if_seen, 1);
        check("cont_ls_first", ls_first, 1'b1);
        @(negedge clk);
        @(negedge clk);

`ifdef MEM_CTRL_MISALIGN_CHECK_EN
        do_ls(17'h10002, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        do_ls(17'h10004, 1'b0, 2'b00, 1'b1, 32'h0, 32'h0000_0033, 32'h0000_0033, 1'b0);
        do_ls(17'h10001, 1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
`endif

        // Reset while the engine is mid-transaction.
        eng_lat = 1000;
        e.own_ls = 1'b0; e.addr = 17'h00030; e.wr = 1'b0; e.nb = 4; e.wdata = 32'h0;
        e.r = 32'h0; e.rdata = 32'h0; e.mis = 1'b0;
        q.push_back(e);
        if_addr = 17'h00030;
        if_req = 1'b1;
        @(negedge clk);
        check("abort_started", mem_start, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_start_low", mem_start, 1'b0);
        check("abort_busy_low", busy, 1'b0);
        check("abort_no_if_done", if_done, 1'b0);
        if_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", if_done | ls_done, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_if_rdata", if_rdata, 32'h0);
        check("abort_ls_rdata", ls_rdata, 32'h0);

        eng_lat = 2;
        do_if(17'h00040, 32'hAABB_CCDD, 32'hDDCC_BBAA);
        @(negedge clk);
        check("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
